// File: rtl/skolem_check_sequencer.sv
// Exhaustive sequencer: walks all 2^N_IN assignments through a Skolem block, counts spec failures.
// Optional build macro SKC_STOP_ON_FAIL_EN ends the run at the first failing assignment.
module skolem_check_sequencer #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  sk_x,
  input  logic [N_OUT-1:0] sk_y,
  output logic [N_IN-1:0]  spec_x,
  output logic [N_OUT-1:0] spec_y,
  input  logic             spec_ok,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             cex_valid,
  output logic [N_IN-1:0]  cex_x,
  output logic [N_OUT-1:0] cex_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CAPTURE, S_CHECK, S_DONE
  } state_t;

  localparam int              SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]      SETTLE_LD = SETTLE_M1[3:0];
  localparam logic [N_IN-1:0] X_ONE     = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t             r_state, w_next;
  logic [3:0]         r_settle;
  logic [N_IN-1:0]    r_sk_x, r_spec_x, r_cex_x;
  logic [N_OUT-1:0]   r_spec_y, r_cex_y;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic               r_pass, r_cex_valid;
  logic               w_last, w_stop, w_abort;

  assign w_last  = &r_sk_x;
  assign w_abort = abort && (r_state != S_IDLE);
`ifdef SKC_STOP_ON_FAIL_EN
  assign w_stop  = w_last || !spec_ok;
`else
  assign w_stop  = w_last;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start && !abort) w_next = S_DRIVE;
      S_DRIVE:   w_next = (SETTLE == 0) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (r_settle == 4'd0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_CHECK;
      S_CHECK:   w_next = w_stop ? S_DONE : S_DRIVE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle    <= '0;
      r_sk_x      <= '0;
      r_spec_x    <= '0;
      r_spec_y    <= '0;
      r_fail_cnt  <= '0;
      r_pass      <= 1'b0;
      r_cex_valid <= 1'b0;
      r_cex_x     <= '0;
      r_cex_y     <= '0;
    end else if (w_abort) begin
      // Partial fail_cnt and counterexample are kept for post-mortem.
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_sk_x      <= '0;
            r_fail_cnt  <= '0;
            r_cex_valid <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_DRIVE: r_settle <= SETTLE_LD;
        S_WAIT:  if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        S_CAPTURE: begin
          r_spec_x <= r_sk_x;
          r_spec_y <= sk_y;
        end
        S_CHECK: begin
          if (!spec_ok) begin
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_ONE;
            if (!r_cex_valid) begin
              r_cex_valid <= 1'b1;
              r_cex_x     <= r_spec_x;
              r_cex_y     <= r_spec_y;
            end
          end
          // pass is resolved on the way into DONE so it is valid alongside the done pulse.
          if (w_stop) r_pass <= (r_fail_cnt == '0) && spec_ok;
          else        r_sk_x <= r_sk_x + X_ONE;
        end
        default: ;
      endcase
    end
  end

  assign sk_x      = r_sk_x;
  assign spec_x    = r_spec_x;
  assign spec_y    = r_spec_y;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign fail_cnt  = r_fail_cnt;
  assign cex_valid = r_cex_valid;
  assign cex_x     = r_cex_x;
  assign cex_y     = r_cex_y;

endmodule

// File: tb/tb_skolem_check_sequencer.sv
// Self-checking bench: two sequencer instances (SETTLE=1/CNT_W=8 and SETTLE=0/CNT_W=2)
// driven with per-assignment fault masks; expectations come from a whole-run reference model.
module tb_skolem_check_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A
  logic       start_a, abort_a, spec_ok_a, busy_a, done_a, pass_a, cex_valid_a;
  logic [2:0] sk_x_a, sk_y_a, spec_x_a, spec_y_a, cex_x_a, cex_y_a;
  logic [7:0] fail_cnt_a;
  logic [2:0] mask_a [8];

  // Instance B
  logic       start_b, abort_b, spec_ok_b, busy_b, done_b, pass_b, cex_valid_b;
  logic [2:0] sk_x_b, sk_y_b, spec_x_b, spec_y_b, cex_x_b, cex_y_b;
  logic [1:0] fail_cnt_b;
  logic [2:0] mask_b [8];

  // Golden Skolem function; the evaluator accepts y iff it equals golden(x).
  function automatic logic [2:0] golden(input logic [2:0] x);
    return x * 3'd5 + 3'd3;
  endfunction

  assign sk_y_a    = golden(sk_x_a) ^ mask_a[sk_x_a];
  assign spec_ok_a = (spec_y_a == golden(spec_x_a));
  assign sk_y_b    = golden(sk_x_b) ^ mask_b[sk_x_b];
  assign spec_ok_b = (spec_y_b == golden(spec_x_b));

  skolem_check_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .sk_x(sk_x_a), .sk_y(sk_y_a), .spec_x(spec_x_a), .spec_y(spec_y_a),
    .spec_ok(spec_ok_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_cnt(fail_cnt_a), .cex_valid(cex_valid_a), .cex_x(cex_x_a), .cex_y(cex_y_a));

  skolem_check_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .sk_x(sk_x_b), .sk_y(sk_y_b), .spec_x(spec_x_b), .spec_y(spec_y_b),
    .spec_ok(spec_ok_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_cnt(fail_cnt_b), .cex_valid(cex_valid_b), .cex_x(cex_x_b), .cex_y(cex_y_b));

  // Observation mux: sel=0 watches A, sel=1 watches B.
  bit         sel = 1'b0;
  logic       o_busy, o_done, o_pass, o_cex_valid;
  logic [2:0] o_sk_x, o_spec_x, o_spec_y, o_cex_x, o_cex_y;
  logic [7:0] o_fail_cnt;
  assign o_busy      = sel ? busy_b      : busy_a;
  assign o_done      = sel ? done_b      : done_a;
  assign o_pass      = sel ? pass_b      : pass_a;
  assign o_cex_valid = sel ? cex_valid_b : cex_valid_a;
  assign o_sk_x      = sel ? sk_x_b      : sk_x_a;
  assign o_spec_x    = sel ? spec_x_b    : spec_x_a;
  assign o_spec_y    = sel ? spec_y_b    : spec_y_a;
  assign o_cex_x     = sel ? cex_x_b     : cex_x_a;
  assign o_cex_y     = sel ? cex_y_b     : cex_y_a;
  assign o_fail_cnt  = sel ? {6'b0, fail_cnt_b} : fail_cnt_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/busy"},      32'(o_busy),      32'd0);
    check({tag, "/done"},      32'(o_done),      32'd0);
    check({tag, "/pass"},      32'(o_pass),      32'd0);
    check({tag, "/sk_x"},      32'(o_sk_x),      32'd0);
    check({tag, "/spec_x"},    32'(o_spec_x),    32'd0);
    check({tag, "/spec_y"},    32'(o_spec_y),    32'd0);
    check({tag, "/fail_cnt"},  32'(o_fail_cnt),  32'd0);
    check({tag, "/cex_valid"}, 32'(o_cex_valid), 32'd0);
    check({tag, "/cex_x"},     32'(o_cex_x),     32'd0);
    check({tag, "/cex_y"},     32'(o_cex_y),     32'd0);
  endtask

  // One complete run on the selected instance, checked cycle by cycle against the model.
  task automatic run_full(input string tag, input bit pulse_busy);
    logic [2:0] m [8];
    int per, sat, nf, first, d_cyc, exp_cnt, last_x;
    for (int i = 0; i < 8; i++) m[i] = sel ? mask_b[i] : mask_a[i];
    per = sel ? 3 : 4;
    sat = sel ? 3 : 255;
    nf = 0;
    first = -1;
    for (int i = 0; i < 8; i++)
      if (m[i] != 3'd0) begin
        nf++;
        if (first < 0) first = i;
      end
`ifdef SKC_STOP_ON_FAIL_EN
    if (first >= 0) begin
      d_cyc = (first + 1) * per + 1; exp_cnt = 1; last_x = first;
    end else begin
      d_cyc = 8 * per + 1; exp_cnt = 0; last_x = 7;
    end
`else
    d_cyc   = 8 * per + 1;
    exp_cnt = (nf > sat) ? sat : nf;
    last_x  = 7;
`endif
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    check({tag, "/c1_fail_cnt"},  32'(o_fail_cnt),  32'd0);
    check({tag, "/c1_cex_valid"}, 32'(o_cex_valid), 32'd0);
    for (int c = 1; c < d_cyc; c++) begin
      check({tag, "/sk_x"}, 32'(o_sk_x), 32'((c - 1) / per));
      check({tag, "/busy"}, 32'(o_busy), 32'd1);
      check({tag, "/done_early"}, 32'(o_done), 32'd0);
      if (pulse_busy && c == 6) set_start(1'b1);
      if (pulse_busy && c == 7) set_start(1'b0);
      @(negedge clk);
    end
    set_start(1'b0);
    check({tag, "/done"},      32'(o_done),      32'd1);
    check({tag, "/pass"},      32'(o_pass),      32'(nf == 0));
    check({tag, "/fail_cnt"},  32'(o_fail_cnt),  32'(exp_cnt));
    check({tag, "/cex_valid"}, 32'(o_cex_valid), 32'(first >= 0));
    check({tag, "/spec_x"},    32'(o_spec_x),    32'(last_x));
    check({tag, "/spec_y"},    32'(o_spec_y),    32'(golden(3'(last_x)) ^ m[last_x]));
    if (first >= 0) begin
      check({tag, "/cex_x"}, 32'(o_cex_x), 32'(first));
      check({tag, "/cex_y"}, 32'(o_cex_y), 32'(golden(3'(first)) ^ m[first]));
    end
    @(negedge clk);
    check({tag, "/done_after"}, 32'(o_done), 32'd0);
    check({tag, "/busy_after"}, 32'(o_busy), 32'd0);
    check({tag, "/pass_held"},  32'(o_pass), 32'(nf == 0));
  endtask

  initial begin
    int exp_part;
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    for (int i = 0; i < 8; i++) begin mask_a[i] = 3'd0; mask_b[i] = 3'd0; end

    // Reset state of both instances
    @(negedge clk);
    sel = 1'b0; #1;
    check_all_zero("reset_a");
    sel = 1'b1; #1;
    check_all_zero("reset_b");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // T1: correct Skolem block, with a start pulse while busy
    run_full("t1_clean", 1'b1);

    // T2: output bit 2 inverted for every x
    for (int i = 0; i < 8; i++) mask_a[i] = 3'b100;
    run_full("t2_bit2", 1'b0);

    // T3: fault only at x=5
    for (int i = 0; i < 8; i++) mask_a[i] = 3'd0;
    mask_a[5] = 3'b011;
    run_full("t3_x5", 1'b0);

    // start together with abort in IDLE: abort wins
    @(negedge clk);
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    check("idle_abort/busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("idle_abort/busy2", 32'(busy_a), 32'd0);
    check("idle_abort/done",  32'(done_a), 32'd0);

    // T4: abort at cycle 10, then restart
    for (int i = 0; i < 8; i++) mask_a[i] = 3'd0;
    mask_a[6] = 3'b001;
`ifndef SKC_STOP_ON_FAIL_EN
    mask_a[1] = 3'b010;
`endif
    exp_part = (mask_a[0] != 3'd0 ? 1 : 0) + (mask_a[1] != 3'd0 ? 1 : 0);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("t4_abort/busy",      32'(busy_a),      32'd0);
    check("t4_abort/done",      32'(done_a),      32'd0);
    check("t4_abort/pass",      32'(pass_a),      32'd0);
    check("t4_abort/fail_cnt",  32'(fail_cnt_a),  32'(exp_part));
    check("t4_abort/cex_valid", 32'(cex_valid_a), 32'(exp_part != 0));
    if (exp_part != 0) check("t4_abort/cex_x", 32'(cex_x_a), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_abort/no_done", 32'(done_a), 32'd0);
    end
    run_full("t4_restart", 1'b0);

    // Randomized fault masks on instance A
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++)
        mask_a[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      run_full("rand_a", 1'b1);
    end

    // T6: SETTLE=0, CNT_W=2, all eight assignments faulty -> saturation
    sel = 1'b1;
    for (int i = 0; i < 8; i++) mask_b[i] = 3'($urandom_range(1, 7));
    run_full("t6_sat", 1'b0);
    for (int i = 0; i < 8; i++)
      mask_b[i] = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    run_full("rand_b", 1'b0);
    sel = 1'b0;

    // T5: asynchronous reset between clock edges mid-run
    for (int i = 0; i < 8; i++) mask_a[i] = 3'b111;
    @(negedge clk);
    sel = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 1; c < 9; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst/idle_busy", 32'(busy_a), 32'd0);
    check("t5_rst/idle_done", 32'(done_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
